// File: rtl/uart_bus_master_pkg.sv
// uart_bus_master shared types: command/response codes, FSM encoding.
// Optional UART_BUS_MASTER_CHECKSUM_EN adds the CSUM state and a 5-byte tx queue.
package uart_bus_master_pkg;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam int FIELD_BYTES = 4;

`ifdef UART_BUS_MASTER_CHECKSUM_EN
  localparam int TXQ_BYTES = FIELD_BYTES + 1;
`else
  localparam int TXQ_BYTES = FIELD_BYTES;
`endif
  localparam int TXQ_W = 8 * TXQ_BYTES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_EXEC,
    S_RDWAIT,
    S_TXLOAD,
    S_TXWAIT
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  // Single-byte response left-aligned in the tx queue.
  function automatic logic [TXQ_W-1:0] rsp_word(input logic [7:0] b);
    return {b, {(TXQ_W-8){1'b0}}};
  endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// UART byte stream + memory bus bundle for uart_bus_master.
// master: bridge side (drives tx/bus/hold); slave: transceiver/memory side.
interface uart_bus_master_if;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        tx_done;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        cpu_hold;

  modport master (
    input  rx_data, rx_done, tx_busy, tx_done, bus_rdata,
    output tx_data, tx_wr, bus_addr, bus_wdata, bus_we, bus_re,
    output cpu_hold
  );

  modport slave (
    output rx_data, rx_done, tx_busy, tx_done, bus_rdata,
    input  tx_data, tx_wr, bus_addr, bus_wdata, bus_we, bus_re,
    input  cpu_hold
  );
endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte idle timer: clr restarts, en counts, expired at TIMEOUT_CYC.
// Ports: clk, rst (async active-low), clr, en, expired.
module uart_frame_timer #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [23:0] cnt_q;

  assign expired = cnt_q == TIMEOUT_CYC;

  // Saturates at TIMEOUT_CYC so expired stays up until the next clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 24'd1;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: W/R/G/H frames -> 32-bit bus access, ACK/NAK/data.
// Ports: clk, rst (async active-low), io (uart_bus_master_if.master); UART_BUS_MASTER_CHECKSUM_EN.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYC = 24'd1000000,
  parameter int          RD_LATENCY = 1,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input logic clk,
  input logic rst,
  uart_bus_master_if.master io
);

  state_t state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [TXQ_W-1:0] txq_q, txq_d;
  logic [2:0] left_q, left_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] lat_q, lat_d;
  logic hold_q, hold_d;
  logic expired, in_frame, last_byte, is_w;

`ifdef UART_BUS_MASTER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  localparam state_t S_POST = S_CSUM;
  assign in_frame = state_q inside {S_ADDR, S_DATA, S_CSUM};
`else
  localparam state_t S_POST = S_EXEC;
  assign in_frame = state_q inside {S_ADDR, S_DATA};
`endif

  assign is_w = cmd_q == CMD_W;
  assign last_byte = idx_q == 2'(FIELD_BYTES - 1);

  assign io.tx_data = txq_q[TXQ_W-1 -: 8];
  assign io.tx_wr = (state_q == S_TXLOAD) && !io.tx_busy;
  assign io.bus_we = (state_q == S_EXEC) && (cmd_q == CMD_W);
  assign io.bus_re = (state_q == S_EXEC) && (cmd_q == CMD_R);
  assign io.bus_addr = {addr_q[31:2], 2'b00};
  assign io.bus_wdata = wdata_q;
  assign io.cpu_hold = hold_q;

  uart_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (io.rx_done),
    .en      (in_frame),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cmd_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      txq_q <= '0;
      left_q <= '0;
      idx_q <= '0;
      lat_q <= '0;
      hold_q <= HOLD_AT_RESET;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      txq_q <= txq_d;
      left_q <= left_d;
      idx_q <= idx_d;
      lat_q <= lat_d;
      hold_q <= hold_d;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    txq_d = txq_q;
    left_d = left_q;
    idx_d = idx_q;
    lat_d = lat_q;
    hold_d = hold_q;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    csum_d = csum_q;
`endif
    unique case (state_q)
      S_IDLE: if (io.rx_done) begin
        cmd_d = io.rx_data;
        idx_d = '0;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
        csum_d = io.rx_data;
`endif
        unique case (1'b1)
          (io.rx_data == CMD_W),
          (io.rx_data == CMD_R): state_d = S_ADDR;
          (io.rx_data == CMD_G),
          (io.rx_data == CMD_H): begin
`ifdef UART_BUS_MASTER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            hold_d = io.rx_data == CMD_H;
            txq_d = rsp_word(RSP_ACK);
            left_d = 3'd1;
            state_d = S_TXLOAD;
`endif
          end
          default: begin
            txq_d = rsp_word(RSP_NAK);
            left_d = 3'd1;
            state_d = S_TXLOAD;
          end
        endcase
      end
      S_ADDR: if (io.rx_done) begin
        addr_d = {addr_q[23:0], io.rx_data};
        idx_d = idx_q + 2'd1;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
        csum_d = csum_q ^ io.rx_data;
`endif
        if (last_byte) state_d = is_w ? S_DATA : S_POST;
      end else if (expired) begin
        state_d = S_IDLE;
      end
      S_DATA: if (io.rx_done) begin
        wdata_d = {wdata_q[23:0], io.rx_data};
        idx_d = idx_q + 2'd1;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
        csum_d = csum_q ^ io.rx_data;
`endif
        if (last_byte) state_d = S_POST;
      end else if (expired) begin
        state_d = S_IDLE;
      end
`ifdef UART_BUS_MASTER_CHECKSUM_EN
      S_CSUM: if (io.rx_done) begin
        if (io.rx_data != csum_q) begin
          txq_d = rsp_word(RSP_NAK);
          left_d = 3'd1;
          state_d = S_TXLOAD;
        end else if (cmd_q == CMD_W || cmd_q == CMD_R) begin
          state_d = S_EXEC;
        end else begin
          hold_d = cmd_q == CMD_H;
          txq_d = rsp_word(RSP_ACK);
          left_d = 3'd1;
          state_d = S_TXLOAD;
        end
      end else if (expired) begin
        state_d = S_IDLE;
      end
`endif
      S_EXEC: if (is_w) begin
        txq_d = rsp_word(RSP_ACK);
        left_d = 3'd1;
        state_d = S_TXLOAD;
      end else begin
        lat_d = 8'd1;
        state_d = S_RDWAIT;
      end
      S_RDWAIT: if (lat_q == 8'(RD_LATENCY)) begin
`ifdef UART_BUS_MASTER_CHECKSUM_EN
        txq_d = {io.bus_rdata, io.bus_rdata[31:24] ^ io.bus_rdata[23:16]
                 ^ io.bus_rdata[15:8] ^ io.bus_rdata[7:0]};
`else
        txq_d = io.bus_rdata;
`endif
        left_d = 3'(TXQ_BYTES);
        state_d = S_TXLOAD;
      end else begin
        lat_d = lat_q + 8'd1;
      end
      S_TXLOAD: if (!io.tx_busy) state_d = S_TXWAIT;
      S_TXWAIT: if (io.tx_done) begin
        if (left_q > 3'd1) begin
          txq_d = txq_q << 8;
          left_d = left_q - 3'd1;
          state_d = S_TXLOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: transceiver + 1-cycle memory model.
// Works with or without UART_BUS_MASTER_CHECKSUM_EN.
module tb_uart_bus_master;
  import uart_bus_master_pkg::*;

  localparam logic [23:0] TO = 24'd40;

  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;

  uart_bus_master_if io();

  uart_bus_master #(
    .TIMEOUT_CYC(TO),
    .RD_LATENCY(1),
    .HOLD_AT_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  int we_cnt, re_cnt, both_cnt, viol_cnt, rst_wr_cnt, busy_cnt;
  logic [31:0] we_addr, we_data, re_addr;
  logic [7:0] tx_log[$];

  always @(posedge clk) begin
    if (io.bus_we) begin
      mem[io.bus_addr[5:2]] <= io.bus_wdata;
      we_cnt++;
      we_addr = io.bus_addr;
      we_data = io.bus_wdata;
    end
    if (io.bus_re) begin
      io.bus_rdata <= mem[io.bus_addr[5:2]];
      re_cnt++;
      re_addr = io.bus_addr;
    end
    if (io.bus_we && io.bus_re) both_cnt++;
    if (!rst && io.tx_wr) rst_wr_cnt++;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      io.tx_busy <= 1'b0;
      io.tx_done <= 1'b0;
      busy_cnt <= 0;
    end else begin
      io.tx_done <= 1'b0;
      if (io.tx_wr) begin
        if (io.tx_busy) viol_cnt++;
        tx_log.push_back(io.tx_data);
        io.tx_busy <= 1'b1;
        busy_cnt <= 5;
      end else if (busy_cnt > 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) begin
          io.tx_busy <= 1'b0;
          io.tx_done <= 1'b1;
        end
      end
    end
  end

  function automatic logic [7:0] log_at(input int i);
    if (i < tx_log.size()) return tx_log[i];
    return 8'hxx;
  endfunction

  function automatic logic [TXQ_W-1:0] rsp_exp(input logic [31:0] w);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    return {w, w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]};
`else
    return w;
`endif
  endfunction

  task automatic clr_mon();
    tx_log.delete();
    we_cnt = 0;
    re_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    io.rx_data = b;
    io.rx_done = 1'b1;
    @(negedge clk);
    io.rx_done = 1'b0;
  endtask

  task automatic send_raw(input logic [71:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send_byte(v[8*i +: 8]);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [71:0] v, input int n);
    logic [7:0] x;
    x = '0;
    for (int i = n - 1; i >= 0; i--) x ^= v[8*i +: 8];
    send_raw(v, n);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    send_byte(x);
    repeat (2) @(negedge clk);
`else
    x = '0;
`endif
  endtask

  task automatic wait_tx(input int n);
    for (int k = 0; k < 300 && tx_log.size() < n; k++) @(negedge clk);
    checks++;
    if (tx_log.size() < n) begin
      errors++;
      $display("FAIL tx_wait: got %0d bytes want %0d", tx_log.size(), n);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    io.rx_done = 1'b0;
    io.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (io.tx_wr !== 1'b0) begin errors++; $display("FAIL rst_tx_wr: got %b want 0", io.tx_wr); end
    checks++; if (io.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", io.tx_data); end
    checks++; if (io.bus_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", io.bus_addr); end
    checks++; if (io.bus_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", io.bus_wdata); end
    checks++; if (io.bus_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", io.bus_we); end
    checks++; if (io.bus_re !== 1'b0) begin errors++; $display("FAIL rst_re: got %b want 0", io.bus_re); end
    checks++; if (io.cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_hold: got %b want 1", io.cpu_hold); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    clr_mon();
    send_frame(72'h57_00003000_DEADBEEF, 9);
    wait_tx(1);
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL wr_we_cycles: got %0d want 1", we_cnt); end
    checks++; if (we_addr !== 32'h3000) begin errors++; $display("FAIL wr_addr: got %h want 00003000", we_addr); end
    checks++; if (we_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data: got %h want deadbeef", we_data); end
    checks++; if (re_cnt !== 0) begin errors++; $display("FAIL wr_re: got %0d want 0", re_cnt); end
    checks++; if (tx_log.size() !== 1) begin errors++; $display("FAIL wr_nbytes: got %0d want 1", tx_log.size()); end
    checks++; if (log_at(0) !== 8'h06) begin errors++; $display("FAIL wr_ack: got %h want 06", log_at(0)); end
  endtask

  task automatic test_read();
    logic [TXQ_W-1:0] er;
    clr_mon();
    er = rsp_exp(32'hDEADBEEF);
    send_frame(72'h52_00003000, 5);
    wait_tx(TXQ_BYTES);
    checks++; if (re_cnt !== 1) begin errors++; $display("FAIL rd_re_cycles: got %0d want 1", re_cnt); end
    checks++; if (re_addr !== 32'h3000) begin errors++; $display("FAIL rd_addr: got %h want 00003000", re_addr); end
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL rd_we: got %0d want 0", we_cnt); end
    checks++; if (tx_log.size() !== TXQ_BYTES) begin errors++; $display("FAIL rd_nbytes: got %0d want %0d", tx_log.size(), TXQ_BYTES); end
    for (int i = 0; i < TXQ_BYTES; i++) begin
      checks++;
      if (log_at(i) !== er[8*(TXQ_BYTES-1-i) +: 8]) begin
        errors++;
        $display("FAIL rd_byte%0d: got %h want %h", i, log_at(i), er[8*(TXQ_BYTES-1-i) +: 8]);
      end
    end
    checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL rd_wr_while_busy: got %0d want 0", viol_cnt); end
  endtask

  task automatic test_nak_go();
    clr_mon();
    send_byte(8'h41);
    wait_tx(1);
    checks++; if (log_at(0) !== 8'h15) begin errors++; $display("FAIL nak_byte: got %h want 15", log_at(0)); end
    checks++; if (we_cnt + re_cnt !== 0) begin errors++; $display("FAIL nak_strobe: got %0d want 0", we_cnt + re_cnt); end
    checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL nak_idle: got %0d want %0d", dut.state_q, S_IDLE); end
    checks++; if (io.cpu_hold !== 1'b1) begin errors++; $display("FAIL go_hold_before: got %b want 1", io.cpu_hold); end
    clr_mon();
    send_frame(72'h47, 1);
    wait_tx(1);
    checks++; if (log_at(0) !== 8'h06) begin errors++; $display("FAIL go_ack: got %h want 06", log_at(0)); end
    checks++; if (io.cpu_hold !== 1'b0) begin errors++; $display("FAIL go_hold_after: got %b want 0", io.cpu_hold); end
    clr_mon();
    send_frame(72'h48, 1);
    wait_tx(1);
    checks++; if (log_at(0) !== 8'h06) begin errors++; $display("FAIL halt_ack: got %h want 06", log_at(0)); end
    checks++; if (io.cpu_hold !== 1'b1) begin errors++; $display("FAIL halt_hold: got %b want 1", io.cpu_hold); end
  endtask

  // Last data byte lands on the very cycle the timer expires: byte wins.
  task automatic test_boundary();
    logic [7:0] x;
    logic [71:0] hdr;
    clr_mon();
    hdr = 72'h57_00003008_CAFEF0;
    x = 8'h0D;
    for (int i = 0; i < 8; i++) x ^= hdr[8*i +: 8];
    send_raw(hdr, 8);
    repeat (int'(TO) - 3) @(negedge clk);
    send_byte(8'h0D);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    repeat (2) @(negedge clk);
    send_byte(x);
`else
    x = '0;
`endif
    wait_tx(1);
    checks++; if (log_at(0) !== 8'h06) begin errors++; $display("FAIL edge_ack: got %h want 06", log_at(0)); end
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL edge_we: got %0d want 1", we_cnt); end
    checks++; if (we_data !== 32'hCAFEF00D) begin errors++; $display("FAIL edge_data: got %h want cafef00d", we_data); end
  endtask

  task automatic test_unaligned_read();
    logic [TXQ_W-1:0] er;
    clr_mon();
    er = rsp_exp(32'hCAFEF00D);
    send_frame(72'h52_0000300A, 5);
    wait_tx(TXQ_BYTES);
    checks++; if (re_addr !== 32'h3008) begin errors++; $display("FAIL ua_addr: got %h want 00003008", re_addr); end
    for (int i = 0; i < TXQ_BYTES; i++) begin
      checks++;
      if (log_at(i) !== er[8*(TXQ_BYTES-1-i) +: 8]) begin
        errors++;
        $display("FAIL ua_byte%0d: got %h want %h", i, log_at(i), er[8*(TXQ_BYTES-1-i) +: 8]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [TXQ_W-1:0] er;
    clr_mon();
    send_byte(8'h57);
    repeat (2) @(negedge clk);
    send_byte(8'h00);
    repeat (int'(TO) + 10) @(negedge clk);
    checks++; if (tx_log.size() !== 0) begin errors++; $display("FAIL to_silent: got %0d bytes want 0", tx_log.size()); end
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL to_we: got %0d want 0", we_cnt); end
    checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL to_idle: got %0d want %0d", dut.state_q, S_IDLE); end
    er = rsp_exp(32'hDEADBEEF);
    send_frame(72'h52_00003000, 5);
    wait_tx(TXQ_BYTES);
    checks++; if (re_cnt !== 1) begin errors++; $display("FAIL to_rd_re: got %0d want 1", re_cnt); end
    for (int i = 0; i < TXQ_BYTES; i++) begin
      checks++;
      if (log_at(i) !== er[8*(TXQ_BYTES-1-i) +: 8]) begin
        errors++;
        $display("FAIL to_byte%0d: got %h want %h", i, log_at(i), er[8*(TXQ_BYTES-1-i) +: 8]);
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    clr_mon();
    send_frame(72'h47, 1);
    wait_tx(1);
    clr_mon();
    send_frame(72'h52_00003000, 5);
    for (int k = 0; k < 300 && tx_log.size() < 2; k++) @(negedge clk);
    checks++; if (tx_log.size() !== 2) begin errors++; $display("FAIL mr_reach: got %0d bytes want 2", tx_log.size()); end
    rst = 1'b0;
    rst_wr_cnt = 0;
    repeat (20) @(negedge clk);
    checks++; if (io.cpu_hold !== 1'b1) begin errors++; $display("FAIL mr_hold: got %b want 1", io.cpu_hold); end
    checks++; if (rst_wr_cnt !== 0) begin errors++; $display("FAIL mr_wr_in_rst: got %0d want 0", rst_wr_cnt); end
    checks++; if (io.tx_data !== 8'h00) begin errors++; $display("FAIL mr_tx_data: got %h want 00", io.tx_data); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (tx_log.size() !== 2) begin errors++; $display("FAIL mr_no_resume: got %0d bytes want 2", tx_log.size()); end
    clr_mon();
    send_frame(72'h57_0000300C_01020304, 9);
    wait_tx(1);
    checks++; if (log_at(0) !== 8'h06) begin errors++; $display("FAIL mr_new_ack: got %h want 06", log_at(0)); end
    checks++; if (we_addr !== 32'h300C) begin errors++; $display("FAIL mr_new_addr: got %h want 0000300c", we_addr); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL we_re_overlap: got %0d want 0", both_cnt); end
  endtask

`ifdef UART_BUS_MASTER_CHECKSUM_EN
  task automatic test_csum();
    clr_mon();
    send_raw(72'h57_00003000_DEADBEEF, 9);
    send_byte(8'h00);
    wait_tx(1);
    checks++; if (log_at(0) !== 8'h15) begin errors++; $display("FAIL cs_bad_nak: got %h want 15", log_at(0)); end
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL cs_bad_we: got %0d want 0", we_cnt); end
    clr_mon();
    send_raw(72'h57_00003000_DEADBEEF, 9);
    send_byte(8'h45);
    wait_tx(1);
    checks++; if (log_at(0) !== 8'h06) begin errors++; $display("FAIL cs_good_ack: got %h want 06", log_at(0)); end
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL cs_good_we: got %0d want 1", we_cnt); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    we_cnt = 0;
    re_cnt = 0;
    both_cnt = 0;
    viol_cnt = 0;
    rst_wr_cnt = 0;
    test_reset();
    test_write();
    test_read();
    test_nak_go();
    test_boundary();
    test_unaligned_read();
    test_timeout();
    test_reset_mid_tx();
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    test_csum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Host-side loader/debug bridge. Consumes bytes from the uart_transceiver receive side and issues 32-bit word reads/writes onto the data/code memory bus as a bus initiator. Returns responses through the transceiver transmit side.
- Serves the direction opposite to CPU-driven UART access: the UART drives the bus. Used to load code memory (0x3000~0x7EFF) and to peek/poke data memory while the CPU is held.

Parameters:
- TIMEOUT_CYC, 24'd1000000, idle cycles allowed between bytes of one frame before the frame is aborted.
- RD_LATENCY, 1, cycles from bus_re to valid bus_rdata (DM is synchronous, 1).
- HOLD_AT_RESET, 1, reset value of cpu_hold.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte from transceiver
- rx_done  in  1  one-cycle pulse, rx_data valid
- tx_data  out  8  byte to transmit
- tx_wr  out  1  one-cycle transmit strobe
- tx_busy  in  1  transmitter busy
- tx_done  in  1  one-cycle pulse, byte sent
- bus_addr  out  32  word address (bits[1:0] forced 0)
- bus_wdata  out  32  write data
- bus_we  out  1  one-cycle write strobe
- bus_re  out  1  one-cycle read strobe
- bus_rdata  in  32  read data, valid RD_LATENCY cycles after bus_re
- cpu_hold  out  1  stalls CPU while high

Behaviour:
- Reset values: tx_data=0, tx_wr=0, bus_addr=0, bus_wdata=0, bus_we=0, bus_re=0, cpu_hold=HOLD_AT_RESET, state=IDLE, timer=0.
- Frames (multi-byte fields MSB first):
  - 'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0
  - 'R'(0x52) A3..A0
  - 'G'(0x47), releases cpu_hold
  - 'H'(0x48), sets cpu_hold
- Responses:
  - ACK 0x06 after W/G/H.
  - R returns 4 data bytes MSB first.
  - NAK 0x15 for an unknown command byte.
- States: IDLE, ADDR(4 bytes), DATA(4 bytes), EXEC, RDWAIT, TXLOAD, TXWAIT.
- IDLE: on rx_done, decode the command.
  - W/R go to ADDR.
  - G/H apply hold on the same edge, then go to TXLOAD with ACK.
  - Other values go to TXLOAD with NAK.
- ADDR/DATA: shift one byte per rx_done. After the 4th byte, W goes ADDR→DATA→EXEC and R goes ADDR→EXEC.
- EXEC, W: bus_we=1 for exactly one cycle with latched addr/wdata, then TXLOAD with ACK.
- EXEC, R: bus_re=1 for one cycle. RDWAIT counts RD_LATENCY cycles, captures bus_rdata, then TXLOAD with 4 bytes queued.
- TXLOAD: when tx_busy=0, pulse tx_wr for one cycle with tx_data held stable, then go to TXWAIT.
- TXWAIT: on tx_done, send the next queued byte (back to TXLOAD) or return to IDLE.
- rx_done arriving outside IDLE/ADDR/DATA is dropped. No queueing; the host must wait for the response.
- Timeout: the timer clears on every rx_done and counts only in ADDR/DATA. When it reaches TIMEOUT_CYC, go to IDLE silently and discard partial fields.
- Simultaneous rx_done and timeout on the same cycle: the byte wins and the timer clears.
- Address: bus_addr = {addr[31:2],2'b00}. Unaligned low bits are silently ignored; no range check.
- Reset mid-frame or mid-transmit: immediate return to reset values. No tx_wr or bus strobe is emitted after reset assertion.
- bus_we and bus_re are never high together and are never high outside EXEC.

Optional Feature:
- Macro: UART_BUS_MASTER_CHECKSUM_EN.
- With the macro defined:
  - W/R/G/H frames carry one trailing byte equal to the XOR of all preceding frame bytes, command included. A CSUM state follows the last field.
  - On mismatch: NAK 0x15, no bus strobe, no hold change.
  - R response gains a 5th byte, the XOR of the 4 data bytes.
- Without the macro: no checksum byte in either direction. CSUM state and XOR registers are absent.

Decomposition:
- Shared package uart_bus_master_pkg holds:
  - command constants CMD_W/CMD_R/CMD_G/CMD_H
  - RSP_ACK=8'h06 and RSP_NAK=8'h15
  - the state encoding
  - the field byte count 4
- One sub-module, uart_frame_timer: TIMEOUT_CYC counter with clear/enable inputs and an expired output. Reset is asynchronous, active-low, same clk/rst.

Test Plan:
- Send 57 00 00 30 00 DE AD BE EF → one cycle bus_we=1, bus_addr=0x00003000, bus_wdata=0xDEADBEEF; tx byte 0x06.
- After the write, send 52 00 00 30 00 → bus_re once at 0x3000; tx bytes DE, AD, BE, EF in order, each tx_wr only while tx_busy=0.
- Send 0x41 → tx 0x15, no bus strobe, state back to IDLE; then a 'G' frame → tx 0x06 and cpu_hold 1→0.
- Send 57 00 then idle TIMEOUT_CYC+1 cycles → no response, no bus_we; a following full R frame is answered correctly.
- Assert rst low mid-R-response after the 2nd data byte → tx_wr stays 0, cpu_hold=HOLD_AT_RESET, a new frame works.
- With UART_BUS_MASTER_CHECKSUM_EN: W frame with a bad checksum → 0x15 and no bus_we; with the correct checksum 0x57^0x30^0xDE^0xAD^0xBE^0xEF → bus_we and 0x06.
